// File: rtl/signed_mac_pipe_if.sv
// Operand/result handshake bundle for signed_mac_pipe.
// The master side feeds operands and accepts results; the slave side is the MAC.
interface signed_mac_pipe_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 2*IN_WIDTH
);
   logic                        in_valid;
   logic                        in_ready;
   logic                        in_first;
   logic                        in_last;
   logic signed [IN_WIDTH-1:0]  in0;
   logic signed [IN_WIDTH-1:0]  in1;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [OUT_WIDTH-1:0] out_data;
   logic                        out_sat;

   modport master (
      output in_valid, in_first, in_last, in0, in1, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_first, in_last, in0, in1, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/signed_mac_pipe.sv
// Three-stage signed multiply-accumulate: magnitudes, product, accumulate/emit.
// Define SIGNED_MAC_SAT_EN to saturate the result to OUT_WIDTH (else it wraps).
module signed_mac_pipe #(
   parameter int IN_WIDTH   = 16,
   parameter int GUARD_BITS = 8,
   parameter int OUT_WIDTH  = 2*IN_WIDTH
) (
   input  logic             CLK,
   input  logic             rst_n,
   signed_mac_pipe_if.slave bus
);
   localparam int PROD_W    = 2*IN_WIDTH;
   localparam int ACC_WIDTH = PROD_W + GUARD_BITS;

   function automatic logic [IN_WIDTH-1:0] mag(input logic [IN_WIDTH-1:0] v);
      // -2^(IN_WIDTH-1) negates to itself, which read unsigned is the right magnitude
      return v[IN_WIDTH-1] ? IN_WIDTH'(~v + 1'b1) : v;
   endfunction

   logic                        stall;
   logic [2:1]                  vld_pipe;
   logic [IN_WIDTH-1:0]         s1_mag0, s1_mag1;
   logic                        s1_sgn, s1_first, s1_last;
   logic [PROD_W-1:0]           mprod;
   logic signed [PROD_W-1:0]    s2_prod;
   logic                        s2_first, s2_last;
   logic signed [ACC_WIDTH-1:0] acc, acc_next;
   logic [OUT_WIDTH-1:0]        conv;
   logic                        clip;
   logic                        out_valid_q, out_sat_q;
   logic [OUT_WIDTH-1:0]        out_data_q;

   assign stall         = out_valid_q & ~bus.out_ready;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

   assign mprod = PROD_W'(s1_mag0) * PROD_W'(s1_mag1);

   always_comb begin
      acc_next = (s2_first ? '0 : acc) + ACC_WIDTH'(s2_prod);
`ifdef SIGNED_MAC_SAT_EN
      // In range only when every bit from OUT_WIDTH-1 upward equals the sign
      clip = ~((&acc_next[ACC_WIDTH-1:OUT_WIDTH-1]) | ~(|acc_next[ACC_WIDTH-1:OUT_WIDTH-1]));
      if (!clip)
         conv = acc_next[OUT_WIDTH-1:0];
      else if (acc_next[ACC_WIDTH-1])
         conv = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         conv = {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
      clip = 1'b0;
      conv = acc_next[OUT_WIDTH-1:0];
`endif
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe    <= '0;
         s1_mag0     <= '0;
         s1_mag1     <= '0;
         s1_sgn      <= 1'b0;
         s1_first    <= 1'b0;
         s1_last     <= 1'b0;
         s2_prod     <= '0;
         s2_first    <= 1'b0;
         s2_last     <= 1'b0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (!stall) begin
         vld_pipe <= {vld_pipe[1], bus.in_valid};
         s1_mag0  <= mag(bus.in0);
         s1_mag1  <= mag(bus.in1);
         s1_sgn   <= bus.in0[IN_WIDTH-1] ^ bus.in1[IN_WIDTH-1];
         s1_first <= bus.in_first;
         s1_last  <= bus.in_last;
         s2_prod  <= s1_sgn ? -mprod : mprod;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         if (vld_pipe[2])
            acc <= acc_next;
         // Not stalled means the held result (if any) was taken this cycle
         if (vld_pipe[2] && s2_last) begin
            out_valid_q <= 1'b1;
            out_data_q  <= conv;
            out_sat_q   <= clip;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_signed_mac_pipe.sv
// Directed bench for signed_mac_pipe: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares whenever a result is taken.
module tb_signed_mac_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   signed_mac_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();
   signed_mac_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) bus16 ();

   signed_mac_pipe #(.IN_WIDTH(16), .GUARD_BITS(8), .OUT_WIDTH(32)) dut (
      .CLK(clk), .rst_n(rst_n), .bus(bus));
   signed_mac_pipe #(.IN_WIDTH(16), .GUARD_BITS(8), .OUT_WIDTH(16)) dut16 (
      .CLK(clk), .rst_n(rst_n), .bus(bus16));

   typedef struct { logic [31:0] data; int rise; } exp_t;
   exp_t q[$];
   exp_t mon_e;
   int   n_vec = 0, n_bad = 0;
   int   cyc = 0, rise_cyc = 0;
   logic prev_vld = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && !prev_vld) rise_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL unexpected_out: got %0h, expected no result", $unsigned(bus.out_data));
            end else begin
               mon_e = q.pop_front();
               chk("out_data", $unsigned(bus.out_data), mon_e.data);
               chk("out_sat", {31'd0, bus.out_sat}, 32'd0);
               if (mon_e.rise >= 0) chk("latency", rise_cyc, mon_e.rise);
            end
         end
      end
      prev_vld = bus.out_valid;
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input bit f, input bit l, output int t);
      int w;
      bus.in_valid = 1'b1; bus.in0 = a; bus.in1 = b;
      bus.in_first = f;    bus.in_last = l;
      w = 0;
      do begin @(negedge clk); w++; end while (!bus.in_ready && w < 50);
      if (!bus.in_ready) begin
         n_vec++; n_bad++;
         $display("FAIL in_ready_timeout: got 0, expected 1");
      end
      t = cyc;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [31:0] d, input int rise);
      exp_t e;
      e.data = d; e.rise = rise;
      q.push_back(e);
   endtask

   task automatic drain();
      int w = 0;
      while (q.size() > 0 && w < 100) begin @(negedge clk); w++; end
      if (q.size() > 0) begin
         n_vec++; n_bad++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
         q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out_valid();
      int w = 0;
      while (!bus.out_valid && w < 50) begin @(negedge clk); w++; end
      chk("wait_out_valid", {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic chk_reset_state();
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data", $unsigned(bus.out_data), 32'd0);
      chk("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, w;
      bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
      bus.in0 = 0; bus.in1 = 0; bus.out_ready = 1;
      bus16.in_valid = 0; bus16.in_first = 0; bus16.in_last = 0;
      bus16.in0 = 0; bus16.in1 = 0; bus16.out_ready = 1;
      #12;
      chk_reset_state();
      @(posedge clk); #1 rst_n = 1'b1;

      // -3 x 5 single sample: -15, visible 3 cycles after transfer
      send(16'hFFFD, 16'h0005, 1, 1, t); push(32'hFFFF_FFF1, t + 3);
      drain();
      // most negative squared
      send(16'h8000, 16'h8000, 1, 1, t); push(32'h4000_0000, t + 3);
      drain();

      // 4 taps with bubbles: 2 - 12 - 30 + 56 = 16
      send(16'd1, 16'd2, 1, 0, t); idle(2);
      send(16'hFFFD, 16'd4, 0, 0, t);
      send(16'd5, 16'hFFFA, 0, 0, t); idle(1);
      send(16'd7, 16'd8, 0, 1, t); push(32'd16, t + 3);
      drain();

      // back-to-back results
      send(16'd100, 16'hFF38, 1, 1, t); push(32'hFFFF_B1E0, -1);   // -20000
      send(16'hFFFF, 16'hFFFF, 1, 1, t); push(32'd1, -1);
      send(16'h7FFF, 16'h7FFF, 1, 1, t); push(32'h3FFF_0001, -1);
      send(16'd3, 16'd3, 1, 0, t);
      send(16'hFFFE, 16'd4, 0, 1, t); push(32'd1, -1);              // 9 - 8
      send(16'd6, 16'd7, 1, 1, t); push(32'd42, -1);
      drain();

      // backpressure: result held 5 cycles, next burst waits
      bus.out_ready = 1'b0;
      send(16'd10, 16'd10, 1, 1, t); push(32'd100, -1);
      wait_out_valid();
      @(posedge clk); #1;
      fork
         begin
            send(16'd1, 16'd1, 1, 0, t);
            send(16'd2, 16'd2, 0, 0, t);
            send(16'd3, 16'd3, 0, 1, t); push(32'd14, -1);          // 1 + 4 + 9
         end
         begin
            repeat (5) begin
               @(negedge clk);
               chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
               chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
               chk("stall_out_data", $unsigned(bus.out_data), 32'd100);
            end
            @(posedge clk); #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // reset while tap 2 of a burst is presented
      send(16'd1, 16'd1, 1, 0, t);
      send(16'd2, 16'd2, 0, 0, t);
      bus.in_valid = 1; bus.in0 = 16'd3; bus.in1 = 16'd3; bus.in_last = 1;
      rst_n = 1'b0;
      #2 chk_reset_state();
      bus.in_valid = 0; bus.in_last = 0;
      idle(2); rst_n = 1'b1;
      send(16'd2, 16'd3, 1, 0, t);
      send(16'd4, 16'd5, 0, 1, t); push(32'd26, t + 3);
      drain();

      // in-flight single sample killed by reset; then no-first burst sums onto zero
      send(16'd9, 16'd9, 1, 1, t);
      rst_n = 1'b0; idle(2); rst_n = 1'b1;
      idle(4);
      send(16'd2, 16'd3, 0, 0, t);
      send(16'd4, 16'd5, 0, 1, t); push(32'd26, t + 3);
      drain();

      // 16-bit result: 2 x (32767 x 2) = 0x1FFFC
      bus16.in_valid = 1; bus16.in0 = 16'h7FFF; bus16.in1 = 16'd2;
      bus16.in_first = 1; bus16.in_last = 0;
      @(posedge clk); #1 bus16.in_first = 0; bus16.in_last = 1;
      @(posedge clk); #1 bus16.in_valid = 0; bus16.in_last = 0;
      w = 0;
      while (!bus16.out_valid && w < 50) begin @(negedge clk); w++; end
      chk("sat16_valid", {31'd0, bus16.out_valid}, 32'd1);
`ifdef SIGNED_MAC_SAT_EN
      chk("sat16_data", {16'd0, $unsigned(bus16.out_data)}, 32'h0000_7FFF);
      chk("sat16_flag", {31'd0, bus16.out_sat}, 32'd1);
`else
      chk("sat16_data", {16'd0, $unsigned(bus16.out_data)}, 32'h0000_FFFC);
      chk("sat16_flag", {31'd0, bus16.out_sat}, 32'd0);
`endif
      idle(3);
      chk("queue_empty", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
